dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU and an external master
//  (SPART bootloader / debug DMA). The CPU has priority; a starvation counter
//  forces an external access after MAX_WAIT blocked cycles, stalling the CPU for
//  one cycle. Sits between the CPU mem stage and dmem; dmem is instantiated by
//  the parent, not here.
// PARAMETERS
//  MAX_WAIT  4  consecutive blocked ext cycles before a forced grant (legal 1..15)
// PORTS
//  clk           in   1           system clock; memory samples on negedge
//  rst           in   1           asynchronous, active-high reset
//  cpu_en_i      in   1           CPU requests access this cycle
//  cpu_we_i      in   1           CPU write enable
//  cpu_addr_i    in   DMEM_DEPTH  CPU address
//  cpu_wdata_i   in   16          CPU write data
//  cpu_rdata_o   out  16          read data, valid late in the same cycle (negedge read)
//  cpu_stall_o   out  1           CPU must hold its request and retry next cycle
//  ext_req_i     in   1           external request; held with addr/we/wdata until ext_gnt_o
//  ext_we_i      in   1           external write enable
//  ext_addr_i    in   DMEM_DEPTH  external address
//  ext_wdata_i   in   16          external write data
//  ext_gnt_o     out  1           access performed this cycle
//  ext_rdata_o   out  16          registered read data
//  ext_rvalid_o  out  1           ext_rdata_o valid; 1-cycle pulse after a granted read
//  mem_we_o      out  1           to dmem we_i
//  mem_addr_o    out  DMEM_DEPTH  to dmem addr_i
//  mem_wdata_o   out  16          to dmem wdata_i
//  mem_rdata_i   in   16          from dmem rdata_o
// BEHAVIOUR
//  - DMEM_DEPTH comes from MiniLab_defs. Grant/mux are combinational from state
//    plus inputs. State, counter, ext_rdata_o, and ext_rvalid_o are registered
//    on posedge clk.
//  - Reset: state=ARB_CPU, wait_cnt=0, ext_rdata_o=0, ext_rvalid_o=0.
//    While rst=1: ext_gnt_o=0, cpu_stall_o=0, mem_we_o=0.
//  - ARB_CPU state:
//      - cpu_en_i=1: CPU owns memory; ext_gnt_o=0.
//      - cpu_en_i=0 and ext_req_i=1: external master owns memory; ext_gnt_o=1.
//      - Neither requesting: mem_we_o=0; the address mux defaults to the CPU.
//  - wait_cnt:
//      - +1 on each cycle with ext_req_i && !ext_gnt_o, saturating at MAX_WAIT.
//      - Cleared on ext_gnt_o, or when ext_req_i=0.
//  - ARB_CPU -> ARB_FORCE when wait_cnt+1==MAX_WAIT in a blocked cycle.
//  - ARB_FORCE state:
//      - ext_gnt_o=ext_req_i; cpu_stall_o=cpu_en_i.
//      - Always returns to ARB_CPU next cycle; wait_cnt cleared.
//      - If ext_req_i=0 (protocol violation), the CPU is served normally and
//        no stall is raised.
//  - cpu_stall_o=1 only in ARB_FORCE with cpu_en_i=1. While stalled, mem_we_o
//    carries the ext write only; a CPU write is never issued.
//  - Bounds:
//      - ext worst-case req->gnt latency is MAX_WAIT+1 cycles.
//      - CPU loses at most 1 cycle per MAX_WAIT+1.
//  - Reads: ext_rdata_o<=mem_rdata_i and ext_rvalid_o<=1 at the posedge ending a
//    granted ext read; ext_rvalid_o=0 otherwise. ext writes give no rvalid.
//  - Back-to-back: ext_req_i held high after a grant issues a new access. Accesses
//    are serialized, so ext-write then CPU-read of the same address returns the
//    new data.
//  - Reset mid-operation: state, counter, and rvalid clear immediately. Memory
//    contents are untouched. A pending ext request is re-arbitrated after reset.
// STRUCTURE
//  - Add typedef enum logic {ARB_CPU, ARB_FORCE} arb_state_t to MiniLab_defs.
//  - No sub-modules; single always_ff for state/cnt/rdata, single always_comb
//    for grant and mux.
// TESTING (MAX_WAIT=4)
//  1. Reset: rst=1 with cpu_en_i=1, cpu_we_i=1 -> mem_we_o=0, ext_rvalid_o=0.
//     Release -> CPU write to 0x010 lands.
//  2. CPU idle; ext write 0xBEEF @0x020, then ext read @0x020 -> gnt each
//     cycle, no stall; ext_rvalid_o pulses 1 cycle after read gnt with 0xBEEF.
//  3. cpu_en_i=1 continuously, ext_req_i=1 -> ext_gnt_o=0 for 4 cycles.
//     5th cycle: ext_gnt_o=1, cpu_stall_o=1. Pattern repeats every 5 cycles.
//  4. Forced ext write 0x1234 @0x030 while the stalled CPU holds a read
//     @0x030 -> next cycle cpu_rdata_o=0x1234.
//  5. ext_req_i drops after 2 blocked cycles, reasserts -> wait_cnt restarts;
//     no forced grant until 4 more blocked cycles.
//  6. Assert rst during ARB_FORCE -> stall and gnt drop asynchronously; state
//     ARB_CPU, wait_cnt=0 after release.

Source files
------------

// File: rtl/MiniLab_defs.sv
// Shared MiniLab definitions: data memory geometry and the dmem arbiter state type.
package MiniLab_defs;

    localparam int DMEM_DEPTH = 10;  // data memory address width
    localparam int DATA_W     = 16;
    localparam int CNT_W      = 4;   // wide enough for MAX_WAIT up to 15

    typedef logic [DMEM_DEPTH-1:0] dmem_addr_t;
    typedef logic [DATA_W-1:0]     dmem_data_t;

    typedef enum logic {ARB_CPU, ARB_FORCE} arb_state_t;

    // Saturating increment of the starvation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input int unsigned max);
        return (cnt >= CNT_W'(max)) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU (priority) and an
// external master. After MAX_WAIT consecutive blocked cycles the external
// request is forced through and the CPU is stalled for that one cycle.
module dmem_arbiter
    import MiniLab_defs::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_en_i,
    input  logic       cpu_we_i,
    input  dmem_addr_t cpu_addr_i,
    input  dmem_data_t cpu_wdata_i,
    output dmem_data_t cpu_rdata_o,
    output logic       cpu_stall_o,
    input  logic       ext_req_i,
    input  logic       ext_we_i,
    input  dmem_addr_t ext_addr_i,
    input  dmem_data_t ext_wdata_i,
    output logic       ext_gnt_o,
    output dmem_data_t ext_rdata_o,
    output logic       ext_rvalid_o,
    output logic       mem_we_o,
    output dmem_addr_t mem_addr_o,
    output dmem_data_t mem_wdata_o,
    input  dmem_data_t mem_rdata_i
);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    dmem_data_t       ext_rdata_q, ext_rdata_d;
    logic             ext_rvalid_q, ext_rvalid_d;
    logic             ext_gnt, cpu_stall, blocked;

    // State, starvation counter and external read-return registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_CPU;
            wait_cnt_q   <= '0;
            ext_rdata_q  <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            ext_rdata_q  <= ext_rdata_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    // Next state: count blocked ext cycles, force a grant on the MAX_WAIT-th one.
    always_comb begin
        blocked      = ext_req_i && !ext_gnt;
        state_d      = ARB_CPU;   // a forced cycle always lasts exactly one cycle
        wait_cnt_d   = '0;        // cleared on grant, on idle ext, and in ARB_FORCE
        if (state_q == ARB_CPU && blocked) begin
            wait_cnt_d = sat_inc(wait_cnt_q, MAX_WAIT);
            if (({1'b0, wait_cnt_q} + 5'd1) == 5'(MAX_WAIT))
                state_d = ARB_FORCE;
        end
        ext_rvalid_d = ext_gnt && !ext_we_i;
        ext_rdata_d  = ext_rvalid_d ? mem_rdata_i : ext_rdata_q;
    end

    // Grant and memory mux; everything is quiet while reset is asserted.
    always_comb begin
        ext_gnt     = 1'b0;
        cpu_stall   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        if (!rst) begin
            if (state_q == ARB_FORCE) begin
                // With no ext request the forced slot simply falls back to the CPU.
                ext_gnt   = ext_req_i;
                cpu_stall = cpu_en_i && ext_req_i;
            end else begin
                ext_gnt   = ext_req_i && !cpu_en_i;
            end
            if (ext_gnt) begin
                mem_we_o    = ext_we_i;
                mem_addr_o  = ext_addr_i;
                mem_wdata_o = ext_wdata_i;
            end else if (cpu_en_i) begin
                mem_we_o    = cpu_we_i;
            end
        end
    end

    assign ext_gnt_o    = ext_gnt;
    assign cpu_stall_o  = cpu_stall;
    assign cpu_rdata_o  = mem_rdata_i;
    assign ext_rdata_o  = ext_rdata_q;
    assign ext_rvalid_o = ext_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then a
// randomized phase, all checked every cycle against a behavioural model.
module tb_dmem_arbiter;
    import MiniLab_defs::*;

    localparam int MW    = 4;
    localparam int MEM_N = 1 << DMEM_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_en, cpu_we, ext_req, ext_we;
    dmem_addr_t cpu_addr, ext_addr;
    dmem_data_t cpu_wdata, ext_wdata;
    dmem_data_t cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
    dmem_addr_t mem_addr;
    logic       cpu_stall, ext_gnt, ext_rvalid, mem_we;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_en_i(cpu_en), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
        .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rdata_o(ext_rdata),
        .ext_rvalid_o(ext_rvalid), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Stand-in for the parent's dmem: write and read sampled on negedge.
    dmem_data_t mem [0:MEM_N-1];
    bit         mem_init = 1'b0;
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: consecutive-blocked count, shadow memory, read return.
    dmem_data_t shadow [0:MEM_N-1];
    bit         mdl_init = 1'b0;
    int         waited;
    logic       exp_rv;
    dmem_data_t exp_rd;

    always @(negedge clk) begin
        logic e_gnt, e_stall, cpu_served;
        #1;
        if (!mdl_init) begin
            for (int i = 0; i < MEM_N; i++) shadow[i] = '0;
            mdl_init = 1'b1;
        end
        if (rst) begin
            chk("rst_gnt", ext_gnt, 0);
            chk("rst_stall", cpu_stall, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_rvalid", ext_rvalid, 0);
            chk("rst_rdata", ext_rdata, 0);
            waited = 0;
            exp_rv = 1'b0;
            exp_rd = '0;
        end else begin
            if (waited == MW) begin
                e_gnt   = ext_req;
                e_stall = cpu_en && ext_req;
                waited  = 0;
            end else begin
                e_gnt   = ext_req && !cpu_en;
                e_stall = 1'b0;
                waited  = (ext_req && !e_gnt) ? waited + 1 : 0;
            end
            cpu_served = cpu_en && !e_gnt;
            chk("gnt", ext_gnt, e_gnt);
            chk("stall", cpu_stall, e_stall);
            chk("rvalid", ext_rvalid, exp_rv);
            chk("ext_rdata", ext_rdata, exp_rd);
            if (e_gnt) begin
                chk("we_ext", mem_we, ext_we);
                chk("addr_ext", mem_addr, ext_addr);
                if (ext_we) chk("wdata_ext", mem_wdata, ext_wdata);
            end else if (cpu_served) begin
                chk("we_cpu", mem_we, cpu_we);
                chk("addr_cpu", mem_addr, cpu_addr);
                if (cpu_we) chk("wdata_cpu", mem_wdata, cpu_wdata);
                else        chk("cpu_rdata", cpu_rdata, shadow[cpu_addr]);
            end else begin
                chk("we_idle", mem_we, 0);
            end
            exp_rv = e_gnt && !ext_we;
            if (exp_rv) exp_rd = shadow[ext_addr];
            if (e_gnt && ext_we)           shadow[ext_addr] = ext_wdata;
            else if (cpu_served && cpu_we) shadow[cpu_addr] = cpu_wdata;
        end
    end

    task automatic drive(input logic ce, cw, input dmem_addr_t ca, input dmem_data_t cd,
                         input logic er, ew, input dmem_addr_t ea, input dmem_data_t ed);
        cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    endtask

    // One clock: inputs change just after posedge, outputs observed after negedge.
    task automatic cyc(input logic ce, cw, input dmem_addr_t ca, input dmem_data_t cd,
                       input logic er, ew, input dmem_addr_t ea, input dmem_data_t ed);
        @(posedge clk); #1;
        drive(ce, cw, ca, cd, er, ew, ea, ed);
        @(negedge clk); #2;
    endtask

    initial begin
        logic [9:0] gpat, spat;
        logic [4:0] g5;
        logic       pg, ps;

        // 1: reset blocks a CPU write; after release it lands.
        drive(1, 1, 10'h010, 16'hA5A5, 0, 0, '0, '0);
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk("t1_rst_we", mem_we, 0);
        chk("t1_rst_rvalid", ext_rvalid, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #2;
        chk("t1_we", mem_we, 1);
        cyc(1, 0, 10'h010, '0, 0, 0, '0, '0);
        chk("t1_rdback", cpu_rdata, 16'hA5A5);

        // 2: CPU idle, ext write then read back.
        cyc(0, 0, '0, '0, 1, 1, 10'h020, 16'hBEEF);
        chk("t2_wgnt", ext_gnt, 1);
        chk("t2_wstall", cpu_stall, 0);
        cyc(0, 0, '0, '0, 1, 0, 10'h020, '0);
        chk("t2_rgnt", ext_gnt, 1);
        chk("t2_no_rv_write", ext_rvalid, 0);
        cyc(0, 0, '0, '0, 0, 0, '0, '0);
        chk("t2_rv", ext_rvalid, 1);
        chk("t2_rdata", ext_rdata, 16'hBEEF);
        cyc(0, 0, '0, '0, 0, 0, '0, '0);
        chk("t2_rv_pulse", ext_rvalid, 0);

        // 3: CPU busy continuously; forced grant every 5th cycle.
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 10'h040, '0, 1, 0, 10'h041, '0);
            gpat[9-k] = ext_gnt;
            spat[9-k] = cpu_stall;
        end
        chk("t3_gnt_pat", 32'(gpat), 32'b0000100001);
        chk("t3_stall_pat", 32'(spat), 32'b0000100001);
        cyc(0, 0, '0, '0, 0, 0, '0, '0);

        // 4: forced ext write under a stalled CPU read of the same address.
        for (int k = 0; k < 5; k++) cyc(1, 0, 10'h030, '0, 1, 1, 10'h030, 16'h1234);
        chk("t4_gnt", ext_gnt, 1);
        chk("t4_stall", cpu_stall, 1);
        cyc(1, 0, 10'h030, '0, 0, 0, '0, '0);
        chk("t4_rd", cpu_rdata, 16'h1234);
        chk("t4_nostall", cpu_stall, 0);

        // 5: ext drops after 2 blocked cycles; counter restarts.
        cyc(1, 0, 10'h040, '0, 1, 0, 10'h020, '0);
        cyc(1, 0, 10'h040, '0, 1, 0, 10'h020, '0);
        cyc(1, 0, 10'h040, '0, 0, 0, 10'h020, '0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 10'h040, '0, 1, 0, 10'h020, '0);
            g5[4-k] = ext_gnt;
        end
        chk("t5_gnt_pat", 32'(g5), 32'b00001);
        cyc(0, 0, '0, '0, 0, 0, '0, '0);

        // 6: reset during the forced cycle.
        for (int k = 0; k < 4; k++) cyc(1, 0, 10'h040, '0, 1, 0, 10'h041, '0);
        @(posedge clk); #3;
        chk("t6_pre_gnt", ext_gnt, 1);
        chk("t6_pre_stall", cpu_stall, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_gnt", ext_gnt, 0);
        chk("t6_async_stall", cpu_stall, 0);
        @(negedge clk); #2;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #2;
        g5[4] = ext_gnt;
        for (int k = 1; k < 5; k++) begin
            cyc(1, 0, 10'h040, '0, 1, 0, 10'h041, '0);
            g5[4-k] = ext_gnt;
        end
        chk("t6_gnt_pat", 32'(g5), 32'b00001);
        cyc(1, 0, 10'h030, '0, 0, 0, '0, '0);
        chk("t6_mem_kept", cpu_rdata, 16'h1234);

        // Randomized traffic: ext holds until granted, CPU holds while stalled.
        pg = ext_gnt; ps = cpu_stall;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (!ext_req || pg) begin
                ext_req   = ($urandom_range(0, 2) != 0);
                ext_we    = $urandom_range(0, 1) == 1;
                ext_addr  = dmem_addr_t'($urandom_range(0, 15));
                ext_wdata = dmem_data_t'($urandom);
            end
            if (!ps) begin
                cpu_en    = ($urandom_range(0, 3) != 0);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = dmem_addr_t'($urandom_range(0, 15));
                cpu_wdata = dmem_data_t'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk); #2;
            pg = ext_gnt; ps = cpu_stall;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
